// File: rtl/sorter_pkg.sv
// sorter_pkg: shared sorter defaults, feeder state encoding and pointer-width helper.
package sorter_pkg;
  localparam int SIZE = 8;
  localparam int WIDTH = 32;
  function automatic int addr_w(input int size);
    return $clog2(size) + 1;
  endfunction
  localparam int ADDR_W = addr_w(SIZE);
  typedef enum logic [1:0] {FILL, STREAM, WAIT} state_t;
endpackage

// File: rtl/sort_feeder_if.sv
// sort_feeder_if: upstream handshake plus sorter-side load signals of the feeder.
interface sort_feeder_if #(
  parameter int size = sorter_pkg::SIZE,
  parameter int width = sorter_pkg::WIDTH
);
  logic in_valid;
  logic [width-1:0] in_data;
  logic in_ready;
  logic sort_done;
  logic start;
  logic [width-1:0] data_out;
  logic busy;
  logic [sorter_pkg::addr_w(size)-1:0] count;
  modport master (output in_valid, in_data, sort_done, input in_ready, start, data_out, busy, count);
  modport slave (input in_valid, in_data, sort_done, output in_ready, start, data_out, busy, count);
endinterface

// File: rtl/feeder_buf.sv
// feeder_buf: batch buffer, one write port and one registered read port.
module feeder_buf #(
  parameter int size = sorter_pkg::SIZE,
  parameter int width = sorter_pkg::WIDTH
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(size)-1:0] wa,
  input  logic [width-1:0] wd,
  input  logic [$clog2(size)-1:0] ra,
  output logic [width-1:0] rd
);
  logic [width-1:0] mem [size];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/sort_feeder.sv
// sort_feeder: buffers a batch of words, then streams them to the sorter and waits for done.
import sorter_pkg::*;
module sort_feeder #(
  parameter int size = SIZE,
  parameter int width = WIDTH
) (
  input logic clk,
  input logic rstn,
  sort_feeder_if.slave bus
);
  localparam int aw = addr_w(size);
  state_t state, state_nxt;
  logic [aw-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [width-1:0] rd_data;
  logic accept, last_in, last_out, clr;
  assign accept = bus.in_valid && bus.in_ready;
  assign last_in = accept && wr_ptr == aw'(size - 1);
  assign last_out = rd_ptr == aw'(size - 1);
  assign clr = state == WAIT && bus.sort_done;
  // Read address runs one ahead so the registered read lands buf[k] in stream cycle k; in FILL it sits on buf[0].
  assign rd_nxt = state == STREAM ? rd_ptr + aw'(1) : clr ? '0 : rd_ptr;
  assign bus.data_out = state == STREAM ? rd_data : '0;
  always_comb begin
    state_nxt = state;
    if (state == FILL && last_in) state_nxt = STREAM;
    if (state == STREAM && last_out) state_nxt = WAIT;
    if (clr) state_nxt = FILL;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.count <= '0;
      bus.in_ready <= 1'b0;
      bus.start <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_ptr <= rd_nxt;
      wr_ptr <= clr ? '0 : accept ? wr_ptr + aw'(1) : wr_ptr;
      bus.count <= clr ? '0 : accept ? bus.count + aw'(1) : bus.count;
      bus.in_ready <= state_nxt == FILL;
      bus.start <= last_in;
      bus.busy <= state_nxt != FILL;
    end
  end
  feeder_buf #(.size(size), .width(width)) u_buf (
    .clk(clk),
    .we(accept),
    .wa(wr_ptr[aw-2:0]),
    .wd(bus.in_data),
    .ra(rd_nxt[aw-2:0]),
    .rd(rd_data)
  );
endmodule

// File: tb/tb_sort_feeder.sv
// tb_sort_feeder: randomized scenarios against a queue model of the feeder batch behaviour.
module tb_sort_feeder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mq[$];
  always #5 clk = ~clk;
  sort_feeder_if #(.size(8), .width(32)) if8();
  sort_feeder_if #(.size(4), .width(32)) if4();
  sort_feeder #(.size(8), .width(32)) u8 (.clk(clk), .rstn(rstn), .bus(if8));
  sort_feeder #(.size(4), .width(32)) u4 (.clk(clk), .rstn(rstn), .bus(if4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [31:0] w);
    if8.in_valid = 1'b1;
    if8.in_data = w;
    mq.push_back(w);
    tick();
    if8.in_valid = 1'b0;
  endtask

  task automatic finish_batch();
    if8.sort_done = 1'b1;
    tick();
    if8.sort_done = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    vectors++;
    if (if8.in_ready !== 1'b0 || if8.start !== 1'b0 || if8.busy !== 1'b0 || if8.data_out !== 32'd0 || if8.count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_hold in_ready=%b start=%b busy=%b data_out=%h count=%0d expected 0 0 0 0 0", if8.in_ready, if8.start, if8.busy, if8.data_out, if8.count);
    end
    rstn = 1'b1;
    tick();
    vectors++;
    if (if8.in_ready !== 1'b1 || if8.count !== 4'd0 || if4.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release in_ready=%b/%b count=%0d expected 1/1 0", if8.in_ready, if4.in_ready, if8.count);
    end
  endtask

  task automatic test_fill();
    logic [31:0] w[8] = '{32'd8, 32'd3, 32'd7, 32'd1, 32'd6, 32'd2, 32'd5, 32'd4};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (if8.in_ready !== 1'b1 || if8.count !== 4'(i)) begin
        miscompares++;
        $display("FAIL fill_count i=%0d in_ready=%b count=%0d expected 1 %0d", i, if8.in_ready, if8.count, i);
      end
      push8(w[i]);
    end
    vectors++;
    if (if8.in_ready !== 1'b0 || if8.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full in_ready=%b busy=%b expected 0 1", if8.in_ready, if8.busy);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (if8.data_out !== mq[k] || if8.start !== (k == 0)) begin
        miscompares++;
        $display("FAIL fill_stream k=%0d data_out=%h start=%b expected %h %b", k, if8.data_out, if8.start, mq[k], k == 0);
      end
      tick();
    end
    vectors++;
    if (if8.data_out !== 32'd0 || if8.busy !== 1'b1 || if8.in_ready !== 1'b0 || if8.start !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_wait data_out=%h busy=%b in_ready=%b start=%b expected 0 1 0 0", if8.data_out, if8.busy, if8.in_ready, if8.start);
    end
    finish_batch();
    vectors++;
    if (if8.in_ready !== 1'b1 || if8.count !== 4'd0 || if8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_done in_ready=%b count=%0d busy=%b expected 1 0 0", if8.in_ready, if8.count, if8.busy);
    end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 8; i++) begin
      push8($urandom);
      if (i < 7) begin
        if8.in_data = $urandom;
        tick();
        vectors++;
        if (if8.count !== 4'(i + 1) || if8.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL gapped_count i=%0d count=%0d in_ready=%b expected %0d 1", i, if8.count, if8.in_ready, i + 1);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (if8.data_out !== mq[k] || if8.start !== (k == 0)) begin
        miscompares++;
        $display("FAIL gapped_stream k=%0d data_out=%h start=%b expected %h %b", k, if8.data_out, if8.start, mq[k], k == 0);
      end
      tick();
    end
    finish_batch();
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 8; i++) push8($urandom);
    if8.in_valid = 1'b1;
    if8.in_data = 32'hDEADBEEF;
    for (int k = 0; k < 11; k++) begin
      vectors++;
      if ((k < 8 && if8.data_out !== mq[k]) || (k >= 8 && if8.data_out !== 32'd0) || if8.count !== 4'd8 || if8.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure k=%0d data_out=%h count=%0d in_ready=%b expected %h 8 0", k, if8.data_out, if8.count, if8.in_ready, k < 8 ? mq[k] : 32'd0);
      end
      tick();
    end
    finish_batch();
    vectors++;
    if (if8.count !== 4'd0 || if8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_done count=%0d in_ready=%b expected 0 1", if8.count, if8.in_ready);
    end
    tick();
    if8.in_valid = 1'b0;
    mq.push_back(32'hDEADBEEF);
    vectors++;
    if (if8.count !== 4'd1) begin
      miscompares++;
      $display("FAIL backpressure_accept count=%0d expected 1", if8.count);
    end
    for (int i = 1; i < 8; i++) push8($urandom);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (if8.data_out !== mq[k] || if8.start !== (k == 0)) begin
        miscompares++;
        $display("FAIL backpressure_stream k=%0d data_out=%h start=%b expected %h %b", k, if8.data_out, if8.start, mq[k], k == 0);
      end
      tick();
    end
    finish_batch();
  endtask

  task automatic test_spurious_done();
    for (int i = 0; i < 3; i++) push8($urandom);
    if8.sort_done = 1'b1;
    tick();
    if8.sort_done = 1'b0;
    vectors++;
    if (if8.count !== 4'd3 || if8.in_ready !== 1'b1 || if8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_fill count=%0d in_ready=%b busy=%b expected 3 1 0", if8.count, if8.in_ready, if8.busy);
    end
    for (int i = 3; i < 8; i++) push8($urandom);
    for (int k = 0; k < 8; k++) begin
      if8.sort_done = (k == 3);
      vectors++;
      if (if8.data_out !== mq[k] || if8.start !== (k == 0) || if8.count !== 4'd8) begin
        miscompares++;
        $display("FAIL spurious_stream k=%0d data_out=%h start=%b count=%0d expected %h %b 8", k, if8.data_out, if8.start, if8.count, mq[k], k == 0);
      end
      tick();
    end
    if8.sort_done = 1'b0;
    vectors++;
    if (if8.busy !== 1'b1 || if8.data_out !== 32'd0 || if8.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_wait busy=%b data_out=%h in_ready=%b expected 1 0 0", if8.busy, if8.data_out, if8.in_ready);
    end
    finish_batch();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) push8($urandom);
    for (int k = 0; k < 4; k++) tick();
    vectors++;
    if (if8.data_out !== mq[4]) begin
      miscompares++;
      $display("FAIL midreset_k4 data_out=%h expected %h", if8.data_out, mq[4]);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if (if8.data_out !== 32'd0 || if8.start !== 1'b0 || if8.busy !== 1'b0 || if8.count !== 4'd0 || if8.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async data_out=%h start=%b busy=%b count=%0d in_ready=%b expected 0 0 0 0 0", if8.data_out, if8.start, if8.busy, if8.count, if8.in_ready);
    end
    #2;
    rstn = 1'b1;
    mq.delete();
    tick();
    vectors++;
    if (if8.in_ready !== 1'b1 || if8.count !== 4'd0 || if8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_release in_ready=%b count=%0d busy=%b expected 1 0 0", if8.in_ready, if8.count, if8.busy);
    end
    push8(32'hFFFFFFFF);
    push8(32'h0);
    for (int i = 2; i < 8; i++) push8($urandom);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (if8.data_out !== mq[k] || if8.start !== (k == 0)) begin
        miscompares++;
        $display("FAIL midreset_stream k=%0d data_out=%h start=%b expected %h %b", k, if8.data_out, if8.start, mq[k], k == 0);
      end
      tick();
    end
    finish_batch();
  endtask

  task automatic test_two_batches();
    logic [31:0] b[2][4] = '{'{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd9, 32'd9, 32'd0, 32'd1}};
    logic [31:0] got[$];
    int starts;
    for (int n = 0; n < 2; n++) begin
      got.delete();
      starts = 0;
      for (int i = 0; i < 4; i++) begin
        if4.in_valid = 1'b1;
        if4.in_data = b[n][i];
        tick();
      end
      if4.in_valid = 1'b0;
      for (int c = 0; c < 14; c++) begin
        if (c < 4) got.push_back(if4.data_out);
        starts += int'(if4.start);
        tick();
      end
      if4.sort_done = 1'b1;
      tick();
      starts += int'(if4.start);
      if4.sort_done = 1'b0;
      vectors++;
      if (starts != 1 || if4.in_ready !== 1'b1 || if4.count !== 3'd0) begin
        miscompares++;
        $display("FAIL batch%0d_ctrl starts=%0d in_ready=%b count=%0d expected 1 1 0", n, starts, if4.in_ready, if4.count);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (got[k] !== b[n][k]) begin
          miscompares++;
          $display("FAIL batch%0d_data k=%0d data_out=%h expected %h", n, k, got[k], b[n][k]);
        end
      end
    end
  endtask

  initial begin
    if8.in_valid = 1'b0;
    if8.in_data = '0;
    if8.sort_done = 1'b0;
    if4.in_valid = 1'b0;
    if4.in_data = '0;
    if4.sort_done = 1'b0;
    repeat (2) tick();
    test_reset();
    test_fill();
    test_gapped();
    test_back_pressure();
    test_spurious_done();
    test_reset_mid();
    test_two_batches();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
